// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
//   fetch_state_e    : fetch FSM encoding (IDLE, REQ, DROP)
//   PC_W_DEFAULT     : default program-counter / address width
//   INST_W_DEFAULT   : default instruction width
//   RESET_PC_DEFAULT : PC after reset, also used by decode/branch logic
//   PC_INC_DEFAULT   : sequential increment for word-addressed memory
package if_fetch_stage_pkg;

  localparam int          PC_W_DEFAULT     = 32;
  localparam int          INST_W_DEFAULT   = 22;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_reg.sv
// One-entry {pc, inst, valid} holding register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : empty the entry (wins over load and drain)
//   load            : capture load_pc/load_inst and mark valid
//   drain           : entry has been moved downstream; mark empty
//   pc, inst, valid : held entry
module if_skid_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int INST_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [PC_W-1:0]   load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      inst  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= load_pc;
      inst  <= load_inst;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID buffer.
//   clk, rst_n              : clock, asynchronous active-low reset
//   stall                   : hazard unit holds the presented instruction
//   redirect, redirect_pc   : taken branch/jump, flush and refetch at target
//   imem_req/addr/ack/rdata : req/ack instruction-memory read port
//   pc_out, inst_out        : presented instruction and its PC
//   inst_valid              : presented instruction is valid
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              INST_W   = INST_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter logic [PC_W-1:0] PC_INC   = PC_W'(PC_INC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid
);

  fetch_state_e      state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_inc;
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic consume;
  logic drain;
  logic ack_in_req;
  logic ack_to_out;
  logic ack_to_skid;
  logic skid_empty_next;

  assign consume     = inst_valid && !stall && !redirect;
  assign drain       = consume && skid_valid;
  // Only a live REQ read delivers data; DROP acks and redirect-cycle acks are discarded.
  assign ack_in_req  = (state_reg == REQ) && imem_ack && !redirect;
  assign ack_to_out  = ack_in_req && (!inst_valid || consume);
  assign ack_to_skid = ack_in_req && !ack_to_out;
  // Skid occupancy after this edge; lets IDLE restart fetching in the drain cycle.
  assign skid_empty_next = (!skid_valid || drain) && !ack_to_skid;
  // Wraps modulo 2^PC_W by construction.
  assign pc_inc = pc_reg + PC_INC;

  if_skid_reg #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .load      (ack_to_skid),
    .drain     (drain),
    .load_pc   (imem_addr),
    .load_inst (imem_rdata),
    .pc        (skid_pc),
    .inst      (skid_inst),
    .valid     (skid_valid)
  );

  // Output register: redirect flushes, skid has priority over fresh data so
  // program order is kept; pc/inst stay stale whenever nothing is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out     <= '0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
    end else if (drain) begin
      pc_out     <= skid_pc;
      inst_out   <= skid_inst;
      inst_valid <= 1'b1;
    end else if (ack_to_out) begin
      pc_out     <= imem_addr;
      inst_out   <= imem_rdata;
      inst_valid <= 1'b1;
    end else if (consume) begin
      inst_valid <= 1'b0;
    end
  end

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect) begin
            pc_reg    <= redirect_pc;
            imem_addr <= redirect_pc;
            imem_req  <= 1'b1;
            state_reg <= REQ;
          end else if (skid_empty_next) begin
            imem_addr <= pc_reg;
            imem_req  <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            pc_reg <= redirect_pc;
            if (imem_ack) begin
              // Old read finished this cycle, so the new one can start at once.
              imem_addr <= redirect_pc;
            end else begin
              // Read still in flight: keep req/addr stable and swallow its ack.
              state_reg <= DROP;
            end
          end else if (imem_ack) begin
            pc_reg <= pc_inc;
            if (skid_empty_next) begin
              imem_addr <= pc_inc;
            end else begin
              imem_req  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            pc_reg <= redirect_pc;
          end
          if (imem_ack) begin
            if (redirect) begin
              imem_addr <= redirect_pc;
              state_reg <= REQ;
            end else if (skid_empty_next) begin
              imem_addr <= pc_reg;
              state_reg <= REQ;
            end else begin
              imem_req  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          imem_req  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
